// File: rtl/multipack_pkg.sv
// rtl/multipack_pkg.sv - shared defaults, lane/bank/store types and slice helpers
// Purpose: common definitions for the multipack lane-gather buffer.
// Contents: default geometry, lane_t/bank_t/store_t, slice legality check,
//           mask popcount and all-ones helpers.
package multipack_pkg;

  localparam int DEF_LANE_W = 3;
  localparam int DEF_LANES  = 4;
  localparam int DEF_BANKS  = 2;

  typedef logic [DEF_LANE_W-1:0] lane_t;
  typedef lane_t [DEF_LANES-1:0] bank_t;
  typedef bank_t [DEF_BANKS-1:0] store_t;

  // Ascending slices must end inside the bank; descending slices must not
  // run below lane 0 (MSB lane sits at base).
  function automatic logic slice_legal(input int base, input int len,
                                       input logic dir, input int lanes);
    if (dir) return (len <= base + 1);
    else     return (base + len <= lanes);
  endfunction

  function automatic int popcount(input logic [DEF_LANES-1:0] m);
    int n;
    n = 0;
    for (int i = 0; i < DEF_LANES; i++) n += int'(m[i]);
    return n;
  endfunction

  function automatic logic all_ones(input logic [DEF_LANES-1:0] m);
    return (popcount(m) == DEF_LANES);
  endfunction

endpackage

// File: rtl/multipack_gather_if.sv
// rtl/multipack_gather_if.sv - lane write port and frame output port bundle
// Purpose: groups the producer-side slice write handshake and the
//          consumer-side frame handshake.
// Modports: master = producer/consumer side, slave = the gather buffer.
interface multipack_gather_if
  import multipack_pkg::*;
#(
  parameter int LANE_W = DEF_LANE_W,
  parameter int LANES  = DEF_LANES,
  parameter int BANKS  = DEF_BANKS,
  parameter int BW     = (BANKS > 1) ? $clog2(BANKS) : 1,
  parameter int LW     = $clog2(LANES),
  parameter int NW     = $clog2(LANES + 1)
) ();

  logic                            in_valid;
  logic                            in_ready;
  logic [BW-1:0]                   in_bank;
  logic [LW-1:0]                   in_base;
  logic [NW-1:0]                   in_len;
  logic                            in_dir;
  logic [LANES-1:0][LANE_W-1:0]    in_data;
  logic                            in_err;
  logic                            out_valid;
  logic                            out_ready;
  logic [BW-1:0]                   out_bank;
  logic [LANES-1:0][LANE_W-1:0]    out_data;
  logic [15:0]                     out_count;

  modport master (
    output in_valid, in_bank, in_base, in_len, in_dir, in_data, out_ready,
    input  in_ready, in_err, out_valid, out_bank, out_data, out_count
  );

  modport slave (
    input  in_valid, in_bank, in_base, in_len, in_dir, in_data, out_ready,
    output in_ready, in_err, out_valid, out_bank, out_data, out_count
  );

endinterface

// File: rtl/multipack_bank.sv
// rtl/multipack_bank.sv - one bank: lane data, written mask, full flag
// Purpose: decodes a pre-validated slice write into lane updates and tracks
//          when every lane has been written.
// Ports: clk, rst_n; wr_en/wr_base/wr_len/wr_dir/wr_data (legal write);
//        pop clears the bank; data/full report bank state.
module multipack_bank
  import multipack_pkg::*;
#(
  parameter int LANE_W = DEF_LANE_W,
  parameter int LANES  = DEF_LANES,
  parameter int LW     = $clog2(LANES),
  parameter int NW     = $clog2(LANES + 1)
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         wr_en,
  input  logic [LW-1:0]                wr_base,
  input  logic [NW-1:0]                wr_len,
  input  logic                         wr_dir,
  input  logic [LANES-1:0][LANE_W-1:0] wr_data,
  input  logic                         pop,
  output logic [LANES-1:0][LANE_W-1:0] data,
  output logic                         full
);

  logic [LANES-1:0][LANE_W-1:0] data_q, data_d;
  logic [LANES-1:0]             mask_q, mask_d;
  logic                         full_q, full_d;
  int                           lo;
  int                           hi;

  always_comb begin
    data_d = data_q;
    mask_d = mask_q;
    // Full follows the completed mask by one edge.
    full_d = full_q | (&mask_q);
    // Both directions reduce to a contiguous lane range [lo, hi] fed from
    // input lane 0 upward.
    lo = wr_dir ? (int'(wr_base) - int'(wr_len) + 1) : int'(wr_base);
    hi = lo + int'(wr_len) - 1;
    if (pop) begin
      data_d = '0;
      mask_d = '0;
      full_d = 1'b0;
    end else if (wr_en) begin
      for (int l = 0; l < LANES; l++) begin
        if (l >= lo && l <= hi) begin
          data_d[l] = wr_data[LW'(l - lo)];
          mask_d[l] = 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      data_q <= '0;
      mask_q <= '0;
      full_q <= 1'b0;
    end else begin
      data_q <= data_d;
      mask_q <= mask_d;
      full_q <= full_d;
    end
  end

  assign data = data_q;
  assign full = full_q;

endmodule

// File: rtl/multipack_gather.sv
// rtl/multipack_gather.sv - lane-gather buffer top: banks, arbiter, counter
// Purpose: accepts lane slices into BANKS banks and offers each full bank as
//          one frame, round-robin between full banks.
// Ports: clk, rst_n (async active-low); bus = multipack_gather_if.slave.
module multipack_gather
  import multipack_pkg::*;
#(
  parameter int LANE_W = DEF_LANE_W,
  parameter int LANES  = DEF_LANES,
  parameter int BANKS  = DEF_BANKS,
  parameter int BW     = (BANKS > 1) ? $clog2(BANKS) : 1,
  parameter int LW     = $clog2(LANES),
  parameter int NW     = $clog2(LANES + 1)
) (
  input  logic               clk,
  input  logic               rst_n,
  multipack_gather_if.slave  bus
);

  logic [BANKS-1:0][LANES-1:0][LANE_W-1:0] bank_data;
  logic [BANKS-1:0]                        bank_full;
  logic [BANKS-1:0]                        bank_wr;
  logic [BANKS-1:0]                        bank_pop;

  logic          bank_ok, legal, accept, pop, found;
  logic [BW-1:0] idx, search_bank, out_bank;
  logic [BW-1:0] rr_q, rr_d, sel_bank_q, sel_bank_d;
  logic          sel_valid_q, sel_valid_d;
  logic          in_err_q, in_err_d;
  logic [15:0]   out_count_q, out_count_d;

  // A bank index past BANKS-1 never stalls; the write is flagged as an error.
  assign bank_ok      = (int'(bus.in_bank) < BANKS);
  assign bus.in_ready = bank_ok ? !bank_full[bus.in_bank] : 1'b1;
  assign legal        = bank_ok && slice_legal(int'(bus.in_base), int'(bus.in_len),
                                               bus.in_dir, LANES);
  assign accept       = bus.in_valid && bus.in_ready;

  for (genvar b = 0; b < BANKS; b++) begin : g_bank
    assign bank_wr[b]  = accept && legal && (bus.in_bank == BW'(b));
    assign bank_pop[b] = pop && (out_bank == BW'(b));

    multipack_bank #(
      .LANE_W (LANE_W),
      .LANES  (LANES),
      .LW     (LW),
      .NW     (NW)
    ) u_bank (
      .clk     (clk),
      .rst_n   (rst_n),
      .wr_en   (bank_wr[b]),
      .wr_base (bus.in_base),
      .wr_len  (bus.in_len),
      .wr_dir  (bus.in_dir),
      .wr_data (bus.in_data),
      .pop     (bank_pop[b]),
      .data    (bank_data[b]),
      .full    (bank_full[b])
    );
  end

  // First full bank at or after rr, wrapping.
  always_comb begin
    search_bank = '0;
    found       = 1'b0;
    idx         = '0;
    for (int i = 0; i < BANKS; i++) begin
      idx = BW'((int'(rr_q) + i) % BANKS);
      if (!found && bank_full[idx]) begin
        search_bank = idx;
        found       = 1'b1;
      end
    end
  end

  // A bank already offered keeps the port until popped, even if a bank
  // closer to rr fills meanwhile.
  assign out_bank      = sel_valid_q ? sel_bank_q : search_bank;
  assign bus.out_bank  = out_bank;
  assign bus.out_valid = |bank_full;
  assign bus.out_data  = bank_data[out_bank];
  assign bus.out_count = out_count_q;
  assign bus.in_err    = in_err_q;
  assign pop           = bus.out_valid && bus.out_ready;

  always_comb begin
    rr_d        = rr_q;
    out_count_d = out_count_q;
    sel_valid_d = bus.out_valid && !bus.out_ready;
    sel_bank_d  = out_bank;
    in_err_d    = accept && !legal;
    if (pop) begin
      rr_d        = (int'(out_bank) == BANKS - 1) ? '0 : out_bank + 1'b1;
      out_count_d = out_count_q + 16'd1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rr_q        <= '0;
      sel_bank_q  <= '0;
      sel_valid_q <= 1'b0;
      in_err_q    <= 1'b0;
      out_count_q <= '0;
    end else begin
      rr_q        <= rr_d;
      sel_bank_q  <= sel_bank_d;
      sel_valid_q <= sel_valid_d;
      in_err_q    <= in_err_d;
      out_count_q <= out_count_d;
    end
  end

endmodule

// File: tb/tb_multipack_gather.sv
// tb/tb_multipack_gather.sv - scoreboard bench for multipack_gather
module tb_multipack_gather;
  import multipack_pkg::*;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  multipack_gather_if bus ();

  multipack_gather dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  typedef struct {
    logic [0:0]  bank;
    logic [11:0] data;
    logic [15:0] count;
  } exp_t;

  exp_t exp_q[$];
  int   n_pass = 0;
  int   n_chk  = 0;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", name, got, exp);
  endtask

  // Monitor: every frame handed over is compared against the next expected one.
  always @(negedge clk) begin
    exp_t e;
    if (rst_n && bus.out_valid && bus.out_ready) begin
      if (exp_q.size() == 0) begin
        n_chk++;
        $display("FAIL unexpected_pop: got bank %0d data 0x%0h, none expected",
                 bus.out_bank, bus.out_data);
      end else begin
        e = exp_q.pop_front();
        chk("pop_bank", 32'(bus.out_bank), 32'(e.bank));
        chk("pop_data", 32'(bus.out_data), 32'(e.data));
        chk("pop_count_before", 32'(bus.out_count), 32'(e.count));
      end
    end
  end

  task automatic cyc(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic wr(input int bank, input int base, input int len, input int dir,
                    input logic [11:0] data);
    int n;
    n = 0;
    bus.in_valid = 1'b1;
    bus.in_bank  = 1'(bank);
    bus.in_base  = 2'(base);
    bus.in_len   = 3'(len);
    bus.in_dir   = 1'(dir);
    bus.in_data  = data;
    while (!bus.in_ready && n < 20) begin
      cyc(1);
      n++;
    end
    if (!bus.in_ready) begin
      n_chk++;
      $display("FAIL write_timeout: in_ready stayed 0 for bank %0d", bank);
    end
    cyc(1);
    bus.in_valid = 1'b0;
  endtask

  task automatic pop_one();
    bus.out_ready = 1'b1;
    cyc(1);
    bus.out_ready = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    bus.in_valid  = 1'b0;
    bus.in_bank   = '0;
    bus.in_base   = '0;
    bus.in_len    = '0;
    bus.in_dir    = 1'b0;
    bus.in_data   = '0;
    bus.out_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;

    // Reset state
    chk("rst_out_valid", 32'(bus.out_valid), 0);
    chk("rst_out_bank",  32'(bus.out_bank),  0);
    chk("rst_out_data",  32'(bus.out_data),  0);
    chk("rst_out_count", 32'(bus.out_count), 0);
    chk("rst_in_err",    32'(bus.in_err),    0);
    chk("rst_in_ready",  32'(bus.in_ready),  1);

    // Bank 0: ascending then descending slice
    exp_q.push_back('{1'b0, 12'b010_100_011_001, 16'd0});
    wr(0, 0, 2, 0, 12'b000_000_011_001);
    wr(0, 3, 2, 1, 12'b000_000_010_100);
    chk("full_latency_gap", 32'(bus.out_valid), 0);
    cyc(1);
    chk("b0_out_valid", 32'(bus.out_valid), 1);
    chk("b0_out_bank",  32'(bus.out_bank),  0);
    chk("b0_out_data",  32'(bus.out_data),  32'b010_100_011_001);
    pop_one();
    chk("b0_count_after", 32'(bus.out_count), 1);
    chk("b0_valid_after", 32'(bus.out_valid), 0);

    // Bank 1: illegal slice, len 0, descending single lane
    wr(1, 3, 2, 0, 12'b000_000_111_111);
    chk("err_pulse", 32'(bus.in_err), 1);
    cyc(1);
    chk("err_clears", 32'(bus.in_err), 0);
    wr(1, 2, 0, 0, 12'b111_111_111_111);
    chk("len0_no_err", 32'(bus.in_err), 0);
    wr(1, 0, 1, 1, 12'b000_000_000_110);
    chk("desc_b0_no_err", 32'(bus.in_err), 0);
    wr(1, 1, 2, 0, 12'b000_000_010_100);
    cyc(2);
    chk("mask_untouched_by_err", 32'(bus.out_valid), 0);
    exp_q.push_back('{1'b1, 12'b101_010_100_110, 16'd1});
    wr(1, 3, 1, 0, 12'b000_000_000_101);
    cyc(1);
    chk("b1_out_bank", 32'(bus.out_bank), 1);
    pop_one();

    // Held selection: bank 1 offered, bank 0 fills behind it (rr=0)
    exp_q.push_back('{1'b1, 12'b101_010_100_110, 16'd2});
    exp_q.push_back('{1'b0, 12'b011_111_001_010, 16'd3});
    wr(1, 0, 4, 0, 12'b101_010_100_110);
    wr(0, 2, 1, 0, 12'b000_000_000_100);
    wr(0, 2, 1, 0, 12'b000_000_000_111);
    wr(0, 0, 2, 0, 12'b000_000_001_010);
    wr(0, 3, 1, 1, 12'b000_000_000_011);
    cyc(2);
    chk("held_bank", 32'(bus.out_bank), 1);
    chk("held_data", 32'(bus.out_data), 32'b101_010_100_110);
    pop_one();
    chk("next_valid", 32'(bus.out_valid), 1);
    chk("next_bank",  32'(bus.out_bank),  0);
    chk("overwrite_lane2", 32'(bus.out_data), 32'b011_111_001_010);

    // Stall on full bank 0, released by the pop
    bus.in_valid = 1'b1;
    bus.in_bank  = 1'b0;
    bus.in_base  = 2'd0;
    bus.in_len   = 3'd2;
    bus.in_dir   = 1'b0;
    bus.in_data  = 12'b000_000_110_111;
    #1;
    chk("stall_ready", 32'(bus.in_ready), 0);
    cyc(1);
    chk("stall_ready_hold", 32'(bus.in_ready), 0);
    chk("stall_data_stable", 32'(bus.out_data), 32'b011_111_001_010);
    bus.out_ready = 1'b1;
    cyc(1);
    bus.out_ready = 1'b0;
    chk("ready_after_pop", 32'(bus.in_ready), 1);
    cyc(1);
    bus.in_valid = 1'b0;
    cyc(1);
    chk("partial_not_valid", 32'(bus.out_valid), 0);
    chk("count_four", 32'(bus.out_count), 4);

    // Bank 1 full, bank 0 partial, then reset
    wr(1, 0, 4, 0, 12'b001_001_001_001);
    cyc(1);
    chk("pre_rst_valid", 32'(bus.out_valid), 1);
    chk("pre_rst_bank",  32'(bus.out_bank),  1);
    rst_n = 1'b0;
    #1;
    chk("rst_mid_valid", 32'(bus.out_valid), 0);
    chk("rst_mid_data",  32'(bus.out_data),  0);
    chk("rst_mid_count", 32'(bus.out_count), 0);
    chk("rst_mid_bank",  32'(bus.out_bank),  0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    wr(0, 2, 2, 0, 12'b000_000_111_111);
    cyc(2);
    chk("partial_discarded", 32'(bus.out_valid), 0);
    chk("scoreboard_drained", 32'(exp_q.size()), 0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/multipack_gather.md
Name: multipack_gather

Overview:
- Parametrised lane-gather buffer on a multi-dimensional packed store: BANKS banks, each LANES lanes of LANE_W bits, declared [BANKS-1:0][LANES-1:0][LANE_W-1:0].
- Writers fill any bank with ascending (+:) or descending (-:) indexed lane slices of variable length.
- A bank whose lanes have all been written is offered downstream as one packed frame through a valid/ready port, with round-robin selection between full banks.
- Sits between lane-granular producers and frame-granular consumers.

Parameters:
- LANE_W, 3, bits per lane
- LANES, 4, lanes per bank (>=2)
- BANKS, 2, number of independently filled banks (>=1)
- BW, $clog2(BANKS) (min 1), bank index width (derived)
- LW, $clog2(LANES), lane index width (derived)
- NW, $clog2(LANES+1), slice length width (derived)

Ports:
- clk  in  1  clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- in_valid  in  1  write request
- in_ready  out  1  = !full[in_bank] (combinational)
- in_bank  in  BW  target bank
- in_base  in  LW  slice anchor lane
- in_len  in  NW  lanes in slice, 0..LANES
- in_dir  in  1  0: ascending [base+:len]; 1: descending [base-:len]
- in_data  in  LANES*LANE_W  packed [LANES-1:0][LANE_W-1:0]; lanes 0..len-1 used
- in_err  out  1  registered pulse: accepted write was out of range
- out_valid  out  1  some bank full
- out_ready  in  1  consumer accepts
- out_bank  out  BW  bank being offered
- out_data  out  LANES*LANE_W  contents of out_bank
- out_count  out  16  frames delivered, wraps

Behaviour:
- Reset (async, rst_n=0): all lane data 0, all written masks 0, full 0, rr pointer 0, in_err 0, out_count 0. Consequently out_valid=0, out_bank=0, out_data=0.
- Write accept: in_valid && in_ready at the clock edge.
- Ascending slice: lane base+k <= in_data lane k, for k=0..len-1. Legal iff base+len <= LANES.
- Descending slice: lane base-len+1+k <= in_data lane k, matching SV -: (MSB lane at base). Legal iff len <= base+1.
- Written-mask bits are set for the lanes written.
- Illegal slice: no lane or mask change; in_err=1 for exactly the next cycle.
- len=0: accepted no-op, no error.
- Rewriting an already-written lane overwrites it; this is legal.
- Full flag: full[b] sets on the edge after the mask becomes all ones. Full-to-out_valid latency is 1 cycle from the completing write.
- While full[b]=1, writes to b stall (in_ready=0). Writes to other banks proceed.
- Output selection (combinational): out_bank = first full bank searching from rr upward, modulo BANKS. out_data = that bank's lanes. out_valid = |full.
- Pop (out_valid && out_ready): the offered bank's mask, data and full flag clear to 0; rr <= out_bank+1 mod BANKS; out_count += 1, wrapping 0xFFFF->0.
- Same cycle, pop of bank A plus accepted write to bank B!=A: both take effect.
- Same cycle, pop of bank A plus write targeting bank A: cannot occur, because in_ready=0 for a full bank.
- out_data/out_bank stay stable while out_valid && !out_ready, except that out_bank may change only if a lower-priority bank… it may not. Once offered, a bank is held until popped: latch the selection when out_valid rises and keep it until the pop.
- Reset asserted mid-operation discards all partial and full banks immediately.

Decomposition:
- Package multipack_pkg: LANE_W/LANES/BANKS defaults, lane_t, bank_t ([LANES-1:0] lane_t), store_t ([BANKS-1:0] bank_t), slice-legality function, popcount/all-ones helper.
- Sub-module multipack_bank: one bank's data, mask, full flag and slice write decode; instantiated BANKS times by a generate loop.
- Top level holds only the arbiter, rr pointer and counter.

Test Plan:
- Reset then bank 0: asc base0 len2 data{011,001}; desc base3 len2 data{010,100} -> cycle after: out_valid=1, out_bank=0, out_data lanes[3:0]={010,100,011,001}; pop -> out_count=1, out_valid=0.
- Asc base3 len2 on bank 1 -> in_err pulses 1 cycle, mask unchanged, no out_valid; desc base0 len1 -> legal, lane0 written.
- Fill bank 1 lanes {101,010,100,110}, hold out_ready=0, then fill bank 0 -> out_bank stays 1 with data stable; pop -> out_bank=0 next cycle; pop -> rr=1.
- Bank 0 full and unpopped, in_bank=0 with in_valid held -> in_ready=0 and no change; pop that cycle -> in_ready=1 next cycle, write lands in the cleared bank.
- Overwrite lane 2 twice (100 then 111) before completing -> delivered lane2=111.
- rst_n low for 1 cycle mid-fill with bank 1 full -> out_valid=0 and out_data=0 immediately; out_count=0.
